core_id_reg_file: RTL and testbench

- General-purpose register file for the core's instruction-decode (ID) stage.
- 32 registers of 32 bits each.
- Two combinational read ports and one synchronous write port.
- Internal write-to-read bypass: an operand read in the same cycle as its writeback returns the new value without a stall.

---
 rtl/core_id_reg_file.sv | 62 ++++++
 tb/tb_core_id_reg_file.sv | 134 +++++++++++++
 2 files changed

// File: rtl/core_id_reg_file.sv
// ID-stage register file: 32x32, two combinational read ports, one write port, reg 0 hardwired to zero.
// Reads have zero latency, with same-cycle write bypass. There is no backpressure; a write is accepted every cycle.
module core_id_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic              rf_write,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wr_en;

  assign wr_en = !rst && rf_write && (waddr != '0);

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_d[i] = '0;
      end
    end else if (wr_en) begin
      regs_d[waddr] = data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // wr_en already excludes reset and address 0, so bypass never leaks into those cases
  always_comb begin
    rd_data1 = '0;
    if (raddr1 != '0) begin
      if (wr_en && (waddr == raddr1)) rd_data1 = data;
      else                            rd_data1 = regs_q[raddr1];
    end
  end

  always_comb begin
    rd_data2 = '0;
    if (raddr2 != '0) begin
      if (wr_en && (waddr == raddr2)) rd_data2 = data;
      else                            rd_data2 = regs_q[raddr2];
    end
  end

endmodule

// File: tb/tb_core_id_reg_file.sv
// Scoreboard bench for core_id_reg_file: the stimulus process pushes expected read data and the monitor compares it.
module tb_core_id_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  raddr1, raddr2, waddr;
  logic        rf_write;
  logic [31:0] data;
  logic [31:0] rd_data1, rd_data2;

  core_id_reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
    .rf_write(rf_write), .waddr(waddr), .data(data),
    .rd_data1(rd_data1), .rd_data2(rd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic [4:0]  a1;
    logic [4:0]  a2;
    int          phase;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          passed = 0;
  int          phase  = 0;

  // Register-file semantics: address 0 reads as zero, and a live write to the addressed register wins.
  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (!rst && rf_write && waddr == a) return data;
    return model[a];
  endfunction

  task automatic cyc(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] d,
                     input logic [4:0] a1, input logic [4:0] a2, input bit chk);
    exp_t e;
    rst = r; rf_write = we; waddr = wa; data = d; raddr1 = a1; raddr2 = a2;
    if (chk) begin
      e.e1 = ref_read(a1); e.e2 = ref_read(a2);
      e.a1 = a1; e.a2 = a2; e.phase = phase;
      sb.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (we && wa != 5'd0) begin
      model[wa] = d;
    end
    #1;
  endtask

  // Monitor: the outputs are combinational and always valid, so compare every pending expectation mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (rd_data1 === e.e1) passed++;
      else $display("FAIL rd_data1 phase %0d raddr1=%0d: got %h expected %h", e.phase, e.a1, rd_data1, e.e1);
      checks++;
      if (rd_data2 === e.e2) passed++;
      else $display("FAIL rd_data2 phase %0d raddr2=%0d: got %h expected %h", e.phase, e.a2, rd_data2, e.e2);
    end
  end

  initial begin
    logic [4:0]  wa, a1, a2;
    logic        r, we;
    int          guard;

    // Reset, then read every address.
    phase = 0;
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    for (int k = 0; k < 32; k++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'(k), 5'(k), 1'b1);

    // Sequential fill, then read back.
    phase = 1;
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, 5'(i), 32'(i + 1), 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 1'b1);

    // A bypass that does not match and a bypass that is disabled.
    phase = 2;
    cyc(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd4, 5'd4, 1'b1);
    cyc(1'b0, 1'b1, 5'd3, 32'd4, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd3, 32'hDEADBEEF, 5'd3, 5'd3, 1'b1);

    // Port-1 bypass sweep.
    phase = 3;
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, 5'(i), 32'(i + 32), 5'(i), 5'd31 - 5'(i), 1'b1);
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 1'b1);

    // Port-2 bypass sweep, then a plain read of reg 10.
    phase = 4;
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, 5'(i), 32'(i + 64), 5'd31 - 5'(i), 5'(i), 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd10, 1'b1);

    // Reset mid-operation, with a write pending on the reset edge.
    phase = 5;
    cyc(1'b1, 1'b1, 5'd7, 32'h11112222, 5'd7, 5'd8, 1'b1);
    for (int k = 0; k < 32; k++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'(k), 5'd31 - 5'(k), 1'b1);

    // Randomized traffic, biased toward address collisions.
    phase = 6;
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 24) == 0);
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      cyc(r, we, wa, $urandom, a1, a2, 1'b1);
    end

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
